float_to_fixed: RTL and testbench

FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

---
 rtl/fx_fl_pkg.sv | 26 ++
 rtl/fp32_classify.sv | 22 ++
 rtl/float_to_fixed.sv | 166 ++++++++++++++++
 tb/tb_float_to_fixed.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fx_fl_pkg.sv
// Shared types and constants for the fp32 -> unsigned 12-bit fixed converter.
package fx_fl_pkg;

    localparam int              FIXED_W      = 12;
    localparam int              EXP_BIAS     = 127;
    localparam int              MAX_UNBIASED = 11;
    localparam logic [11:0]     FIXED_MAX    = 12'hFFF;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ALIGN,
        ROUND,
        HOLD
    } state_t;

    // Operand category resolved in DECODE; only K_NUM goes through the rounder.
    typedef enum logic [2:0] {
        K_NUM,
        K_ZERO,
        K_OVF,
        K_NEG,
        K_NAN
    } kind_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational special-case decode of an IEEE 754 single-precision word.
module fp32_classify (
    input  logic [31:0] f,
    output logic        sign,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic [7:0]  exp_f;
    logic [22:0] man_f;

    assign exp_f = f[30:23];
    assign man_f = f[22:0];

    assign sign    = f[31];
    // Zeros and denormals are treated alike: both convert to 0 with no flag.
    assign is_zero = (exp_f == 8'd0);
    assign is_inf  = (exp_f == 8'hFF) && (man_f == 23'd0);
    assign is_nan  = (exp_f == 8'hFF) && (man_f != 23'd0);

endmodule

// File: rtl/float_to_fixed.sv
// Multi-cycle fp32 -> unsigned 12-bit integer converter, round-to-nearest-even,
// with saturation and per-result status flags; valid/ready on both sides.
module float_to_fixed
    import fx_fl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] float_in,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [11:0] fixed_out,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        ovf_o,
    output logic        unf_o,
    output logic        neg_o,
    output logic        nan_o
);

    state_t             state_q, state_d;
    logic [31:0]        float_q;
    kind_t              kind_q, kind_d;
    logic signed [9:0]  u_q, u_d;
    logic [23:0]        sig_q;
    logic [11:0]        int_q, int_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;

    logic               c_sign, c_zero, c_inf, c_nan;

    logic [4:0]         shift;
    logic [23:0]        shifted;
    logic [23:0]        mask;
    logic [12:0]        res13;
    logic [11:0]        fix_d;
    logic               ovf_d, unf_d, neg_d, nan_d;

    assign in_ready_o = (state_q == IDLE);

    fp32_classify u_classify (
        .f       (float_q),
        .sign    (c_sign),
        .is_zero (c_zero),
        .is_inf  (c_inf),
        .is_nan  (c_nan)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = DECODE;
            DECODE:  state_d = ALIGN;
            ALIGN:   state_d = ROUND;
            ROUND:   state_d = HOLD;
            HOLD:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DECODE: unbias the exponent and sort the operand into a category.
    always_comb begin
        u_d = $signed({2'b00, float_q[30:23]}) - 10'(EXP_BIAS);
        if (c_nan)                           kind_d = K_NAN;
        else if (c_zero)                     kind_d = K_ZERO;
        else if (c_sign)                     kind_d = K_NEG;
        else if (c_inf)                      kind_d = K_OVF;
        else if (int'(u_d) > MAX_UNBIASED)   kind_d = K_OVF;
        else                                 kind_d = K_NUM;
    end

    // ALIGN: integer part plus guard/sticky. Shift is 12..23 whenever u is in range.
    always_comb begin
        shift    = 5'd0;
        shifted  = 24'd0;
        mask     = 24'd0;
        int_d    = 12'd0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        if (u_q >= 10'sd0) begin
            shift    = 5'd23 - u_q[4:0];
            shifted  = sig_q >> shift;
            int_d    = shifted[11:0];
            guard_d  = sig_q[shift - 5'd1];
            mask     = (24'd1 << (shift - 5'd1)) - 24'd1;
            sticky_d = |(sig_q & mask);
        end else if (u_q == -10'sd1) begin
            guard_d  = 1'b1;
            sticky_d = |sig_q[22:0];
        end else begin
            sticky_d = 1'b1;
        end
    end

    // ROUND: nearest-even in 13 bits, then saturate or flag.
    always_comb begin
        res13 = {1'b0, int_q} + {12'd0, guard_q & (sticky_q | int_q[0])};
        fix_d = 12'd0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        neg_d = 1'b0;
        nan_d = 1'b0;
        case (kind_q)
            K_NUM: begin
                if (res13[12]) begin
                    fix_d = FIXED_MAX;
                    ovf_d = 1'b1;
                end else begin
                    fix_d = res13[11:0];
                    unf_d = (res13 == 13'd0);
                end
            end
            K_OVF: begin
                fix_d = FIXED_MAX;
                ovf_d = 1'b1;
            end
            K_NEG:   neg_d = 1'b1;
            K_NAN:   nan_d = 1'b1;
            default: fix_d = 12'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            float_q     <= 32'd0;
            kind_q      <= K_ZERO;
            u_q         <= 10'sd0;
            sig_q       <= 24'd0;
            int_q       <= 12'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            fixed_out   <= 12'd0;
            out_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
            unf_o       <= 1'b0;
            neg_o       <= 1'b0;
            nan_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid_i) float_q <= float_in;
                DECODE: begin
                    kind_q <= kind_d;
                    u_q    <= u_d;
                    sig_q  <= {1'b1, float_q[22:0]};
                end
                ALIGN: begin
                    int_q    <= int_d;
                    guard_q  <= guard_d;
                    sticky_q <= sticky_d;
                end
                ROUND: begin
                    fixed_out   <= fix_d;
                    ovf_o       <= ovf_d;
                    unf_o       <= unf_d;
                    neg_o       <= neg_d;
                    nan_o       <= nan_d;
                    out_valid_o <= 1'b1;
                end
                HOLD: if (out_ready_i) out_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed + randomized bench for float_to_fixed against a real-arithmetic model.
module tb_float_to_fixed;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] float_in;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [11:0] fixed_out;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        ovf_o, unf_o, neg_o, nan_o;

    int n_chk = 0;
    int n_err = 0;

    float_to_fixed dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .float_in    (float_in),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fixed_out   (fixed_out),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .ovf_o       (ovf_o),
        .unf_o       (unf_o),
        .neg_o       (neg_o),
        .nan_o       (nan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: value of the float as a real, then RNE to an integer in [0,4095].
    // Flags returned as {ovf,unf,neg,nan}.
    task automatic ref_model(input logic [31:0] f, output logic [11:0] v, output logic [3:0] fl);
        int  e;
        real x, frac;
        int  ip, r;
        v  = 12'd0;
        fl = 4'b0000;
        e  = int'(f[30:23]);
        if (e == 255 && f[22:0] != 23'd0)      fl = 4'b0001;
        else if (e == 0)                        fl = 4'b0000;
        else if (f[31])                         fl = 4'b0010;
        else if (e == 255) begin
            v  = 12'hFFF;
            fl = 4'b1000;
        end else begin
            x = 1.0 + real'(f[22:0]) / 8388608.0;
            for (int k = 0; k < e - 127; k++) x = x * 2.0;
            for (int k = 0; k < 127 - e; k++) x = x / 2.0;
            if (x >= 4096.0) begin
                v  = 12'hFFF;
                fl = 4'b1000;
            end else begin
                ip   = $rtoi(x);
                frac = x - real'(ip);
                r    = ip;
                if (frac > 0.5 || (frac == 0.5 && (ip % 2) == 1)) r = ip + 1;
                if (r >= 4096) begin
                    v  = 12'hFFF;
                    fl = 4'b1000;
                end else begin
                    v = 12'(r);
                    if (r == 0) fl = 4'b0100;
                end
            end
        end
    endtask

    // Issue one operand from IDLE (called #1 after an edge), check latency,
    // result, stability under stall, and the release handshake.
    task automatic do_op(input logic [31:0] f, input logic [11:0] ev, input logic [3:0] efl,
                         input int stall);
        int          n;
        logic [11:0] hv;
        logic [3:0]  hfl;
        chk("ready_idle", 32'(in_ready_o), 32'd1);
        float_in   = f;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        float_in   = $urandom;
        chk("ready_busy", 32'(in_ready_o), 32'd0);
        n = 0;
        while (!out_valid_o && n < 10) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk($sformatf("value_%h", f), 32'(fixed_out), 32'(ev));
        chk($sformatf("flags_%h", f), 32'({ovf_o, unf_o, neg_o, nan_o}), 32'(efl));
        hv  = fixed_out;
        hfl = {ovf_o, unf_o, neg_o, nan_o};
        for (int s = 0; s < stall; s++) begin
            in_valid_i = (s == 1);
            @(posedge clk_i); #1;
            in_valid_i = 1'b0;
            chk("stall_valid", 32'(out_valid_o), 32'd1);
            chk("stall_ready", 32'(in_ready_o), 32'd0);
            chk("stall_value", 32'({fixed_out, ovf_o, unf_o, neg_o, nan_o}), 32'({hv, hfl}));
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        chk("post_valid", 32'(out_valid_o), 32'd0);
        chk("post_ready", 32'(in_ready_o), 32'd1);
        chk("post_hold", 32'({fixed_out, ovf_o, unf_o, neg_o, nan_o}), 32'({hv, hfl}));
    endtask

    typedef struct {
        logic [31:0] f;
        logic [11:0] v;
        logic [3:0]  fl;
    } vec_t;

    initial begin
        vec_t        dir[$];
        logic [31:0] f;
        logic [11:0] mv;
        logic [3:0]  mfl;
        int          quiet;

        rst_i       = 1'b1;
        float_in    = 32'd0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_outs", 32'({fixed_out, ovf_o, unf_o, neg_o, nan_o}), 32'd0);
        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i); #1;

        dir.push_back('{32'h3F800000, 12'h001, 4'b0000});
        dir.push_back('{32'h457FF000, 12'hFFF, 4'b0000});
        dir.push_back('{32'h457FF800, 12'hFFF, 4'b1000});
        dir.push_back('{32'h7F800000, 12'hFFF, 4'b1000});
        dir.push_back('{32'h4B800000, 12'hFFF, 4'b1000});
        dir.push_back('{32'h40200000, 12'h002, 4'b0000});
        dir.push_back('{32'h40600000, 12'h004, 4'b0000});
        dir.push_back('{32'h3F000000, 12'h000, 4'b0100});
        dir.push_back('{32'h3F400000, 12'h001, 4'b0000});
        dir.push_back('{32'hBF800000, 12'h000, 4'b0010});
        dir.push_back('{32'h7FC00000, 12'h000, 4'b0001});
        dir.push_back('{32'hFFC00001, 12'h000, 4'b0001});
        dir.push_back('{32'h80000000, 12'h000, 4'b0000});
        dir.push_back('{32'h00000001, 12'h000, 4'b0000});
        dir.push_back('{32'hFF800000, 12'h000, 4'b0010});
        dir.push_back('{32'h3E800000, 12'h000, 4'b0100});
        dir.push_back('{32'h3F000001, 12'h001, 4'b0000});
        dir.push_back('{32'h45000000, 12'h800, 4'b0000});
        foreach (dir[i]) do_op(dir[i].f, dir[i].v, dir[i].fl, (i == 2) ? 5 : 0);

        // Reset while the operand sits in ALIGN: it must vanish.
        float_in   = 32'h40A00000;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_ready", 32'(in_ready_o), 32'd1);
        chk("midrst_outs", 32'({fixed_out, ovf_o, unf_o, neg_o, nan_o}), 32'd0);
        quiet = 1;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (out_valid_o) quiet = 0;
        end
        chk("midrst_no_valid", 32'(quiet), 32'd1);
        do_op(32'h41200000, 12'h00A, 4'b0000, 0);

        // Randomized operands, exponent biased toward the interesting window.
        for (int i = 0; i < 300; i++) begin
            f = $urandom;
            if ($urandom_range(0, 3) != 0) f[30:23] = 8'($urandom_range(112, 140));
            if ($urandom_range(0, 3) != 0) f[31] = 1'b0;
            ref_model(f, mv, mfl);
            do_op(f, mv, mfl, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
